// File: rtl/cam_cfg_pkg.sv
// rtl/cam_cfg_pkg.sv - shared types and constants for the camera SCCB configuration walker
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    BITS,
    STOP,
    GAP,
    DELAY,
    DONE
  } cfg_state_e;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;
  localparam int          SCCB_BITS = 27;

  // Three 9-bit phases; the don't-care slot of each phase is left high.
  function automatic logic [SCCB_BITS-1:0] sccb_frame(input logic [7:0]  id,
                                                      input logic [15:0] entry);
    return {id, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/cam_sccb_config_if.sv
// rtl/cam_sccb_config_if.sv - control, table and SCCB pin bundle of the configuration walker
interface cam_sccb_config_if #(
  parameter int ROM_AW = 8
);

  logic              start;
  logic              busy;
  logic              done;
  logic [ROM_AW-1:0] writes_done;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              sioc;
  logic              siod_o;
  logic              siod_oe;

  modport master (
    input  start,
    input  rom_data,
    output busy,
    output done,
    output writes_done,
    output rom_addr,
    output sioc,
    output siod_o,
    output siod_oe
  );

  modport slave (
    output start,
    output rom_data,
    input  busy,
    input  done,
    input  writes_done,
    input  rom_addr,
    input  sioc,
    input  siod_o,
    input  siod_oe
  );

endinterface

// File: rtl/cam_config_rom.sv
// rtl/cam_config_rom.sv - synchronous register table for the camera, terminated by CFG_END
module cam_config_rom
  import cam_cfg_pkg::*;
#(
  parameter int ROM_AW = 8
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] data_q;
  logic [15:0] data_d;

  function automatic logic [15:0] rom_entry(input int unsigned idx);
    case (idx)
      0:       rom_entry = 16'h1280;  // COM7 soft reset, must be followed by a settle delay
      1:       rom_entry = CFG_DELAY;
      2:       rom_entry = 16'h1101;
      3:       rom_entry = 16'h1214;
      4:       rom_entry = 16'h40D0;
      5:       rom_entry = 16'h3A04;
      6:       rom_entry = 16'h8C00;
      7:       rom_entry = 16'h0C04;
      8:       rom_entry = 16'h3E19;
      9:       rom_entry = 16'h703A;
      10:      rom_entry = 16'h7135;
      11:      rom_entry = 16'h7211;
      12:      rom_entry = 16'h73F1;
      13:      rom_entry = 16'hA202;
      default: rom_entry = CFG_END;
    endcase
  endfunction

  always_comb begin
    data_d = rom_entry(32'(addr));
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/cam_sccb_config.sv
// rtl/cam_sccb_config.sv - walks the camera register table and issues one 3-phase SCCB write per entry
module cam_sccb_config
  import cam_cfg_pkg::*;
#(
  parameter int         CLK_DIV      = 125,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         ROM_AW       = 8,
  parameter int         DELAY_CYCLES = 500000,
  parameter int         GAP_QB       = 8
) (
  input  logic              clk,
  input  logic              reset,
  cam_sccb_config_if.master cfg
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DLY_W  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int QB_MAX = (GAP_QB > 4) ? GAP_QB : 4;
  localparam int QB_W   = $clog2(QB_MAX);

  cfg_state_e             state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [QB_W-1:0]        qb_q, qb_d;
  logic [4:0]             bit_q, bit_d;
  logic [3:0]             pos_q, pos_d;
  logic [SCCB_BITS-1:0]   sr_q, sr_d;
  logic                   fetch_q, fetch_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [ROM_AW-1:0]      addr_q, addr_d;
  logic [ROM_AW-1:0]      wr_q, wr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sioc_q, sioc_d;
  logic                   siod_q, siod_d;
  logic                   oe_q, oe_d;

  logic running;
  logic tick;
  logic accept;
  logic frame3_end;
  logic bit_end;
  logic frame_end;
  logic gap_end;
  logic dly_end;
  logic addr_last;

  assign running    = state_q inside {START, BITS, STOP, GAP};
  assign tick       = running && (div_q == DIV_W'(CLK_DIV - 1));
  assign accept     = cfg.start && (state_q inside {IDLE, DONE});
  assign frame3_end = tick && (qb_q == QB_W'(2));
  assign bit_end    = tick && (qb_q == QB_W'(3));
  assign frame_end  = bit_end && (bit_q == 5'(SCCB_BITS - 1));
  assign gap_end    = tick && (qb_q == QB_W'(GAP_QB - 1));
  assign dly_end    = (dly_q == DLY_W'(DELAY_CYCLES - 1));
  assign addr_last  = &addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (cfg.start) state_d = FETCH;
      FETCH: begin
        if (fetch_q) begin
          if (cfg.rom_data == CFG_END)        state_d = DONE;
          else if (cfg.rom_data == CFG_DELAY) state_d = DELAY;
          else                                state_d = START;
        end
      end
      START: if (frame3_end) state_d = BITS;
      BITS:  if (frame_end) state_d = STOP;
      // The last table slot is consumed without wrapping back to entry 0.
      STOP:  if (frame3_end) state_d = addr_last ? DONE : GAP;
      GAP:   if (gap_end) state_d = FETCH;
      DELAY: if (dly_end) state_d = addr_last ? DONE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sioc_d = 1'b1;
    siod_d = 1'b1;
    oe_d   = 1'b1;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    case (state_q)
      START: begin
        siod_d = (qb_q == QB_W'(0));
        sioc_d = (qb_q != QB_W'(2));
      end
      BITS: begin
        sioc_d = (qb_q == QB_W'(1)) || (qb_q == QB_W'(2));
        siod_d = sr_q[SCCB_BITS-1];
        oe_d   = (pos_q != 4'd8);
      end
      STOP: begin
        sioc_d = (qb_q != QB_W'(0));
        siod_d = (qb_q == QB_W'(2));
      end
      default: ;
    endcase
  end

  always_comb begin
    div_d   = '0;
    qb_d    = qb_q;
    bit_d   = bit_q;
    pos_d   = pos_q;
    sr_d    = sr_q;
    fetch_d = 1'b0;
    dly_d   = '0;
    addr_d  = addr_q;
    wr_d    = wr_q;

    if (running) div_d = tick ? '0 : div_q + 1'b1;

    if (state_d != state_q) qb_d = '0;
    else if (tick)          qb_d = (state_q == BITS && qb_q == QB_W'(3)) ? '0 : qb_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          addr_d = '0;
          wr_d   = '0;
        end
      end
      FETCH: begin
        // Second FETCH cycle holds valid ROM data; the first cycle's load is overwritten.
        fetch_d = ~fetch_q;
        sr_d    = sccb_frame(DEV_ADDR, cfg.rom_data);
        bit_d   = '0;
        pos_d   = '0;
      end
      BITS: begin
        if (bit_end) begin
          sr_d  = {sr_q[SCCB_BITS-2:0], 1'b1};
          bit_d = bit_q + 5'd1;
          pos_d = (pos_q == 4'd8) ? 4'd0 : pos_q + 4'd1;
        end
      end
      STOP: begin
        if (frame3_end) begin
          wr_d = wr_q + 1'b1;
          if (!addr_last) addr_d = addr_q + 1'b1;
        end
      end
      DELAY: begin
        dly_d = dly_q + 1'b1;
        if (dly_end && !addr_last) addr_d = addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      qb_q    <= '0;
      bit_q   <= '0;
      pos_q   <= '0;
      sr_q    <= '1;
      fetch_q <= 1'b0;
      dly_q   <= '0;
      addr_q  <= '0;
      wr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b1;
      oe_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      qb_q    <= qb_d;
      bit_q   <= bit_d;
      pos_q   <= pos_d;
      sr_q    <= sr_d;
      fetch_q <= fetch_d;
      dly_q   <= dly_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sioc_q  <= sioc_d;
      siod_q  <= siod_d;
      oe_q    <= oe_d;
    end
  end

  assign cfg.busy        = busy_q;
  assign cfg.done        = done_q;
  assign cfg.writes_done = wr_q;
  assign cfg.rom_addr    = addr_q;
  assign cfg.sioc        = sioc_q;
  assign cfg.siod_o      = siod_q;
  assign cfg.siod_oe     = oe_q;

endmodule

// File: tb/tb_cam_sccb_config.sv
// tb/tb_cam_sccb_config.sv - scoreboard bench for the SCCB configuration walker
module tb_cam_sccb_config;
  import cam_cfg_pkg::*;

  localparam int          CLK_DIV      = 4;
  localparam int          ROM_AW       = 2;
  localparam int          DELAY_CYCLES = 100;
  localparam int          GAP_QB       = 8;
  localparam logic [7:0]  DEV_ADDR     = 8'h42;
  localparam int          ENTRY_CYC    = 122 * CLK_DIV + 2;
  localparam int          XFER_CYC     = 114 * CLK_DIV;
  localparam logic [26:0] OE_MASK      = 27'b111111110_111111110_111111110;

  typedef struct {
    logic [26:0] bits;
    logic [26:0] oe;
    int          nbits;
  } frame_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cam_sccb_config_if #(.ROM_AW(ROM_AW)) bus ();

  cam_sccb_config #(
    .CLK_DIV(CLK_DIV), .DEV_ADDR(DEV_ADDR), .ROM_AW(ROM_AW),
    .DELAY_CYCLES(DELAY_CYCLES), .GAP_QB(GAP_QB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cfg  (bus)
  );

  logic [15:0] rom_mem [1 << ROM_AW];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];
  frame_t      got_q[$];
  int          start_ts[$];
  int          start_cnt = 0;
  int          stop_cnt  = 0;

  // SCCB slave model: open-drain SIOD with pull-up, sampled on SIOC rising edges.
  logic        mon_sd;
  logic        mon_psioc = 1'b1;
  logic        mon_psd   = 1'b1;
  logic        mon_in    = 1'b0;
  logic [27:0] mon_bits;
  logic [27:0] mon_oe;
  int          mon_n;
  frame_t      mon_f;

  always @(negedge clk) begin
    mon_sd = bus.siod_oe ? bus.siod_o : 1'b1;
    if (reset) begin
      mon_in = 1'b0;
    end else if (bus.sioc && mon_psioc && mon_psd && !mon_sd) begin
      start_cnt++;
      start_ts.push_back(cyc);
      mon_in   = 1'b1;
      mon_n    = 0;
      mon_bits = '0;
      mon_oe   = '0;
    end else if (bus.sioc && mon_psioc && !mon_psd && mon_sd) begin
      stop_cnt++;
      if (mon_in) begin
        // 27 data clocks plus the SIOC rise that precedes STOP
        mon_f.bits  = mon_bits[27:1];
        mon_f.oe    = mon_oe[27:1];
        mon_f.nbits = mon_n;
        got_q.push_back(mon_f);
      end
      mon_in = 1'b0;
    end else if (bus.sioc && !mon_psioc && mon_in) begin
      mon_bits = {mon_bits[26:0], bus.siod_o};
      mon_oe   = {mon_oe[26:0], bus.siod_oe};
      mon_n++;
    end
    mon_psioc = bus.sioc;
    mon_psd   = mon_sd;
  end

  task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    rom_mem[0] = e0;
    rom_mem[1] = e1;
    rom_mem[2] = e2;
    rom_mem[3] = e3;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 1;
    while (bus.done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic drain_scoreboard(input string tag);
    frame_t      f;
    logic [23:0] e;
    logic [23:0] g;
    while (got_q.size() > 0) begin
      f = got_q.pop_front();
      g = {f.bits[26:19], f.bits[17:10], f.bits[8:1]};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected_frame: got %h, required none", tag, g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s frame_id_reg_val: got %h, required %h", tag, g, e);
        end
        n_cmp++;
        if (f.nbits != 28) begin
          n_fail++;
          $display("FAIL %s frame_clocks: got %0d, required 28", tag, f.nbits);
        end
        n_cmp++;
        if (f.oe !== OE_MASK) begin
          n_fail++;
          $display("FAIL %s frame_oe: got %b, required %b", tag, f.oe, OE_MASK);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_frames: got %0d outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp += 7;
    if (bus.sioc !== 1'b1)          begin n_fail++; $display("FAIL reset_sioc: got %b, required 1", bus.sioc); end
    if (bus.siod_o !== 1'b1)        begin n_fail++; $display("FAIL reset_siod_o: got %b, required 1", bus.siod_o); end
    if (bus.siod_oe !== 1'b1)       begin n_fail++; $display("FAIL reset_siod_oe: got %b, required 1", bus.siod_oe); end
    if (bus.busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %b, required 0", bus.done); end
    if (bus.writes_done !== 2'd0)   begin n_fail++; $display("FAIL reset_writes_done: got %0d, required 0", bus.writes_done); end
    if (bus.rom_addr !== 2'd0)      begin n_fail++; $display("FAIL reset_rom_addr: got %0d, required 0", bus.rom_addr); end
    reset = 1'b0;
  endtask

  task automatic test_single_write;
    int cycles;
    int s0;
    int p0;
    load_rom(16'h1280, CFG_END, CFG_END, CFG_END);
    exp_q.push_back({DEV_ADDR, 16'h1280});
    s0 = start_cnt;
    p0 = stop_cnt;
    pulse_start();
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", bus.busy); end
    wait_done(2000, cycles);
    n_cmp += 6;
    if (bus.done !== 1'b1)        begin n_fail++; $display("FAIL single_done: got %b, required 1", bus.done); end
    if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL single_busy_end: got %b, required 0", bus.busy); end
    if (bus.writes_done !== 2'd1) begin n_fail++; $display("FAIL single_writes_done: got %0d, required 1", bus.writes_done); end
    if (cycles != 1 + ENTRY_CYC + 2) begin
      n_fail++; $display("FAIL single_walk_cycles: got %0d, required %0d", cycles, 1 + ENTRY_CYC + 2);
    end
    if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL single_start_conditions: got %0d, required 1", start_cnt - s0); end
    if (stop_cnt - p0 != 1)  begin n_fail++; $display("FAIL single_stop_conditions: got %0d, required 1", stop_cnt - p0); end
    drain_scoreboard("single");
  endtask

  task automatic test_delay_marker;
    int cycles;
    int s0;
    int delta;
    load_rom(16'h1280, CFG_DELAY, 16'h1101, CFG_END);
    exp_q.push_back({DEV_ADDR, 16'h1280});
    exp_q.push_back({DEV_ADDR, 16'h1101});
    s0 = start_ts.size();
    pulse_start();
    wait_done(4000, cycles);
    n_cmp += 5;
    if (bus.done !== 1'b1)        begin n_fail++; $display("FAIL delay_done: got %b, required 1", bus.done); end
    if (bus.writes_done !== 2'd2) begin n_fail++; $display("FAIL delay_writes_done: got %0d, required 2", bus.writes_done); end
    if (bus.rom_addr !== 2'd3)    begin n_fail++; $display("FAIL delay_rom_addr: got %0d, required 3", bus.rom_addr); end
    if (cycles != 1 + 2 * ENTRY_CYC + 4 + DELAY_CYCLES) begin
      n_fail++; $display("FAIL delay_walk_cycles: got %0d, required %0d", cycles, 1 + 2 * ENTRY_CYC + 4 + DELAY_CYCLES);
    end
    if (start_ts.size() - s0 != 2) begin
      n_fail++; $display("FAIL delay_start_count: got %0d, required 2", start_ts.size() - s0);
    end else begin
      delta = start_ts[s0 + 1] - start_ts[s0];
      if (delta != XFER_CYC + GAP_QB * CLK_DIV + 4 + DELAY_CYCLES) begin
        n_fail++; $display("FAIL delay_start_spacing: got %0d, required %0d", delta, XFER_CYC + GAP_QB * CLK_DIV + 4 + DELAY_CYCLES);
      end
    end
    drain_scoreboard("delay");
  endtask

  task automatic test_start_while_busy;
    int cycles;
    int s0;
    load_rom(16'h1280, CFG_END, CFG_END, CFG_END);
    exp_q.push_back({DEV_ADDR, 16'h1280});
    s0 = start_cnt;
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();
    wait_done(2000, cycles);
    n_cmp += 4;
    if (bus.done !== 1'b1)        begin n_fail++; $display("FAIL busy_start_done: got %b, required 1", bus.done); end
    if (bus.writes_done !== 2'd1) begin n_fail++; $display("FAIL busy_start_writes_done: got %0d, required 1", bus.writes_done); end
    if (bus.rom_addr !== 2'd1)    begin n_fail++; $display("FAIL busy_start_rom_addr: got %0d, required 1", bus.rom_addr); end
    if (start_cnt - s0 != 1)      begin n_fail++; $display("FAIL busy_start_frames: got %0d, required 1", start_cnt - s0); end
    drain_scoreboard("busy_start");
    exp_q.push_back({DEV_ADDR, 16'h1280});
    pulse_start();
    n_cmp += 4;
    if (bus.rom_addr !== 2'd0)    begin n_fail++; $display("FAIL restart_rom_addr: got %0d, required 0", bus.rom_addr); end
    if (bus.done !== 1'b0)        begin n_fail++; $display("FAIL restart_done: got %b, required 0", bus.done); end
    if (bus.busy !== 1'b1)        begin n_fail++; $display("FAIL restart_busy: got %b, required 1", bus.busy); end
    if (bus.writes_done !== 2'd0) begin n_fail++; $display("FAIL restart_writes_done: got %0d, required 0", bus.writes_done); end
    wait_done(2000, cycles);
    n_cmp++;
    if (bus.writes_done !== 2'd1) begin n_fail++; $display("FAIL restart_writes_end: got %0d, required 1", bus.writes_done); end
    drain_scoreboard("restart");
  endtask

  task automatic test_reset_mid_bits;
    int cycles;
    load_rom(16'h1280, 16'h1101, CFG_END, CFG_END);
    pulse_start();
    repeat (150) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp += 5;
    if (bus.sioc !== 1'b1)     begin n_fail++; $display("FAIL abort_sioc: got %b, required 1", bus.sioc); end
    if (bus.siod_o !== 1'b1)   begin n_fail++; $display("FAIL abort_siod_o: got %b, required 1", bus.siod_o); end
    if (bus.siod_oe !== 1'b1)  begin n_fail++; $display("FAIL abort_siod_oe: got %b, required 1", bus.siod_oe); end
    if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
    if (bus.rom_addr !== 2'd0) begin n_fail++; $display("FAIL abort_rom_addr: got %0d, required 0", bus.rom_addr); end
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({DEV_ADDR, 16'h1280});
    exp_q.push_back({DEV_ADDR, 16'h1101});
    pulse_start();
    wait_done(3000, cycles);
    n_cmp += 2;
    if (bus.done !== 1'b1)        begin n_fail++; $display("FAIL abort_rerun_done: got %b, required 1", bus.done); end
    if (bus.writes_done !== 2'd2) begin n_fail++; $display("FAIL abort_rerun_writes: got %0d, required 2", bus.writes_done); end
    drain_scoreboard("abort_rerun");
  endtask

  task automatic test_no_end_marker;
    int cycles;
    int p0;
    load_rom(16'h1280, 16'h1101, 16'h1234, 16'h5678);
    exp_q.push_back({DEV_ADDR, 16'h1280});
    exp_q.push_back({DEV_ADDR, 16'h1101});
    exp_q.push_back({DEV_ADDR, 16'h1234});
    exp_q.push_back({DEV_ADDR, 16'h5678});
    p0 = stop_cnt;
    pulse_start();
    wait_done(5000, cycles);
    n_cmp += 4;
    if (bus.done !== 1'b1)     begin n_fail++; $display("FAIL noend_done: got %b, required 1", bus.done); end
    if (bus.rom_addr !== 2'd3) begin n_fail++; $display("FAIL noend_rom_addr: got %0d, required 3", bus.rom_addr); end
    if (cycles != 1 + 3 * ENTRY_CYC + 2 + XFER_CYC) begin
      n_fail++; $display("FAIL noend_walk_cycles: got %0d, required %0d", cycles, 1 + 3 * ENTRY_CYC + 2 + XFER_CYC);
    end
    if (stop_cnt - p0 != 4) begin n_fail++; $display("FAIL noend_writes: got %0d, required 4", stop_cnt - p0); end
    repeat (1000) @(negedge clk);
    n_cmp += 3;
    if (stop_cnt - p0 != 4) begin n_fail++; $display("FAIL noend_no_fifth: got %0d, required 4", stop_cnt - p0); end
    if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL noend_busy_idle: got %b, required 0", bus.busy); end
    if (bus.sioc !== 1'b1)  begin n_fail++; $display("FAIL noend_bus_idle: got %b, required 1", bus.sioc); end
    drain_scoreboard("noend");
  endtask

  initial begin
    bus.start = 1'b0;
    load_rom(CFG_END, CFG_END, CFG_END, CFG_END);
    test_reset();
    test_single_write();
    test_delay_marker();
    test_start_while_busy();
    test_reset_mid_bits();
    test_no_end_marker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_sccb_config.md
Name: cam_sccb_config

Overview:
- Sequences power-up configuration of the GPIO_0-attached camera over its SCCB two-wire port (SIOC/SIOD).
- Walks a register table held in sub-module cam_config_rom and issues one 3-phase SCCB write per entry.
- Honours delay and end markers in the table and reports progress to software through the Avalon-facing wrapper.
- Sits beside the camera capture path inside soc_system; it configures the camera and carries no pixel data.

Parameters:
- CLK_DIV, 125, clk cycles per SCCB quarter-bit. At 50 MHz this gives 4*125 = 500 cycles per bit, i.e. 100 kHz.
- DEV_ADDR, 8'h42, SCCB write ID sent in phase 1.
- ROM_AW, 8, table address width (max 256 entries).
- DELAY_CYCLES, 500000, cycles waited for a delay marker (10 ms at 50 MHz).
- GAP_QB, 8, idle quarter-bits between transactions.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a full table walk
- busy  out  1  high from accepted start until done
- done  out  1  sticky; set at end marker, cleared by the next accepted start
- writes_done  out  ROM_AW  count of SCCB writes completed in the current walk
- rom_addr  out  ROM_AW  table index
- rom_data  in  16  {reg[15:8], val[7:0]}; valid one cycle after rom_addr changes (synchronous ROM)
- sioc  out  1  SCCB clock, push-pull
- siod_o  out  1  SCCB data value; the wrapper drives the pin as siod_oe ? siod_o : 'z
- siod_oe  out  1  SCCB data output enable

Behaviour:
- Reset values: busy=0, done=0, writes_done=0, rom_addr=0, sioc=1, siod_o=1, siod_oe=1 (bus idle high), state=IDLE.
- Reset mid-transaction aborts immediately. The outputs return to their reset values the next cycle; no STOP condition is generated.
- Quarter-bit tick: a counter counts 0..CLK_DIV-1 and asserts tick on wrap. The counter runs only in START/BITS/STOP/GAP and clears on entry to each of those states.
- start is accepted in IDLE or DONE only; it is ignored while busy. On acceptance: rom_addr=0, writes_done=0, done=0, busy=1, go to FETCH.
- FETCH: 2 cycles (address issue, then data capture).
  - Captured 16'hFFFF -> DONE.
  - Captured 16'hFFF0 -> DELAY.
  - Anything else: load shift register {DEV_ADDR, reg, val}, go to START.
- START: tick 0 siod_o=1, sioc=1; tick 1 siod_o=0; tick 2 sioc=0. Then go to BITS.
- BITS: 27 bits (3 phases x 9), MSB first per phase. Each bit spans 4 ticks:
  - q0: sioc=0, siod updated.
  - q1: sioc=1.
  - q2: sioc=1.
  - q3: sioc=0.
  - In the 9th bit of each phase (don't-care), siod_oe=0 (released). The ACK is not sampled; SCCB has no failure reporting.
- STOP: q0 sioc=0, siod_o=0, siod_oe=1; q1 sioc=1; q2 siod_o=1. Then increment writes_done and rom_addr, go to GAP.
- GAP: GAP_QB ticks with the bus idle high, then FETCH.
- DELAY: counts DELAY_CYCLES cycles with the bus idle, then rom_addr+1 and FETCH. writes_done is not incremented.
- DONE: busy=0, done=1, bus idle. Waits for start.
- rom_addr wrap: if rom_addr reaches 2^ROM_AW-1 without an end marker, that entry is still processed, then the block goes to DONE (no wrap to 0).
- siod changes only while sioc=0, except the START/STOP edges.
- Transaction length: 3+108+3 ticks = 114*CLK_DIV cycles. Adding GAP and FETCH, each table entry takes 122*CLK_DIV+2 cycles.

Decomposition:
- Package cam_cfg_pkg holds:
  - state enum (IDLE, FETCH, START, BITS, STOP, GAP, DELAY, DONE)
  - marker constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0
  - SCCB_BITS=27
- Sub-module cam_config_rom: synchronous ROM, ROM_AW address bits, 16-bit data, initialised with the camera's register list ending in CFG_END.

Test Plan:
- Reset then start: with CLK_DIV=4 and ROM {12'h80 -> 16'h1280, FFFF}, siod carries 0x42, X, 0x12, X, 0x80, X. Each 9th bit has siod_oe=0. writes_done=1, then done=1 and busy=0.
- START/STOP framing: siod falls while sioc=1 exactly once before bit 0. siod rises while sioc=1 exactly once after bit 26. An SCCB slave model decodes reg 0x12 = 0x80.
- Delay marker: ROM {1280, FFF0, 1101, FFFF} with DELAY_CYCLES=100. The second START begins at least 100 cycles after the first GAP ends, and writes_done ends at 2.
- Start while busy: a pulse mid-BITS is ignored. Bit stream and writes_done are unchanged; a start pulse after done restarts at rom_addr=0 with done cleared.
- Reset mid-BITS: the next cycle gives sioc=1, siod_o=1, siod_oe=1, busy=0, rom_addr=0. A fresh start completes the full table correctly.
- Table with no end marker (ROM_AW=2, four data entries): exactly 4 writes, then DONE, with no fifth transaction.
